// File: rtl/tetris_board.sv
// tetris_board: playfield controller. Holds the settled-block bitmap and the
// falling horizontal bar, applies gravity and left/right moves, and emits the
// game-event pulses for the register file plus a row-read port for display.
// Bit c of a row is column c (column 0 = left); row 0 is the top row.
// Optional feature: define TETRIS_HARD_DROP_EN to enable the hard-drop button.
module tetris_board #(
  parameter int ROWS     = 16,
  parameter int COLS     = 10,
  parameter int TICK_DIV = 50000000
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      start_btn,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_drop,
  input  logic [31:0]               shape_in,
  input  logic [$clog2(ROWS)-1:0]   disp_row,
  output logic [COLS-1:0]           disp_bits,
  output logic                      change_shape,
  output logic                      stop,
  output logic                      clear,
  output logic                      start_over,
  output logic                      game_over,
  output logic [$clog2(COLS)-1:0]   piece_x,
  output logic [$clog2(ROWS)-1:0]   piece_y
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_FALL, S_MERGE, S_SCAN, S_SHIFT, S_OVER
  } state_e;

  // Bar of width w (1..4) starting at column x, clipped to the playfield.
  function automatic logic [COLS-1:0] bar_mask(input logic [CW-1:0] x, input logic [2:0] w);
    logic [4:0]      ones;
    logic [COLS+3:0] wide;
    ones = (5'd1 << w) - 5'd1;
    wide = {{(COLS-1){1'b0}}, ones} << x;
    return wide[COLS-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [COLS-1:0]  board_q [ROWS];
  logic [COLS-1:0]  board_d [ROWS];
  logic [CW-1:0]    x_q, x_d;
  logic [RW-1:0]    y_q, y_d;
  logic [RW-1:0]    scan_q, scan_d;
  logic [2:0]       w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_fall_q, first_fall_d;
  logic             start_q, left_q, right_q;

  logic             start_edge, left_edge, right_edge;
  logic             drop_force, grav_tick;
  logic [2:0]       w_new;
  logic [CW-1:0]    x_new;
  logic [RW-1:0]    y_inc;
  logic [COLS-1:0]  mask_new, mask_cur, mask_l, mask_r;

  assign start_edge = start_btn & ~start_q;
  assign left_edge  = btn_left  & ~left_q;
  assign right_edge = btn_right & ~right_q;

  assign w_new    = {1'b0, shape_in[1:0]} + 3'd1;
  assign x_new    = CW'((COLS - int'(w_new)) / 2);
  assign y_inc    = y_q + 1'b1;
  assign mask_new = bar_mask(x_new, w_new);
  assign mask_cur = bar_mask(x_q, w_q);
  assign mask_l   = bar_mask(x_q - 1'b1, w_q);
  assign mask_r   = bar_mask(x_q + 1'b1, w_q);
  assign grav_tick = (cnt_q == TICK_LAST) | drop_force;

  // Only the two code bits of shape_in select the piece width.
  logic unused_shape;
  assign unused_shape = ^shape_in[31:2];

`ifdef TETRIS_HARD_DROP_EN
  logic drop_q, drop_act_q, drop_act_d, drop_edge;
  assign drop_edge  = btn_drop & ~drop_q;
  assign drop_force = drop_act_q | drop_edge;
  // The drop stays armed only while the same piece keeps falling.
  assign drop_act_d = (state_q == S_FALL) && (state_d == S_FALL) && (drop_act_q || drop_edge);

  // Hard-drop button history and latched drop request.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      drop_q     <= 1'b0;
      drop_act_q <= 1'b0;
    end else begin
      drop_q     <= btn_drop;
      drop_act_q <= drop_act_d;
    end
  end
`else
  logic unused_drop;
  assign drop_force  = 1'b0;
  assign unused_drop = btn_drop;
`endif

  // Next-state logic for the game FSM, board, piece and counters.
  always_comb begin
    // NOTE: every target gets its hold/default value first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    board_d      = board_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    cnt_d        = cnt_q;
    scan_d       = scan_q;
    first_fall_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        for (int r = 0; r < ROWS; r++) board_d[r] = '0;
        if (start_btn) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        w_d   = w_new;
        x_d   = x_new;
        y_d   = '0;
        cnt_d = '0;
        if ((board_q[0] & mask_new) != '0) begin
          state_d = S_OVER;
        end else begin
          state_d      = S_FALL;
          first_fall_d = 1'b1;
        end
      end
      S_FALL: begin
        cnt_d = (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
        if (grav_tick) begin
          // Horizontal edges arriving on a gravity tick are dropped.
          if (y_q == ROW_LAST || (board_q[y_inc] & mask_cur) != '0) state_d = S_MERGE;
          else y_d = y_inc;
        end else if (left_edge && !right_edge) begin
          if (x_q != '0 && (board_q[y_q] & mask_l) == '0) x_d = x_q - 1'b1;
        end else if (right_edge && !left_edge) begin
          if ((int'(x_q) + int'(w_q)) < COLS && (board_q[y_q] & mask_r) == '0) x_d = x_q + 1'b1;
        end
      end
      S_MERGE: begin
        board_d[y_q] = board_q[y_q] | mask_cur;
        scan_d       = ROW_LAST;
        state_d      = S_SCAN;
      end
      S_SCAN: begin
        if (&board_q[scan_q])   state_d = S_SHIFT;
        else if (scan_q == '0)  state_d = S_SPAWN;
        else                    scan_d  = scan_q - 1'b1;
      end
      S_SHIFT: begin
        // Collapse everything above the full row by one; rescan the same row.
        for (int r = 1; r < ROWS; r++) begin
          if (RW'(r) <= scan_q) board_d[r] = board_q[r-1];
        end
        board_d[0] = '0;
        state_d    = S_SCAN;
      end
      S_OVER: begin
        if (start_edge) begin
          for (int r = 0; r < ROWS; r++) board_d[r] = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, board and piece registers.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q      <= S_IDLE;
      // NOTE: the board is a flop array, not a RAM, so it can and must be
      // cleared by reset; a RAM macro would need an explicit clear sequence.
      for (int r = 0; r < ROWS; r++) board_q[r] <= '0;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= 3'd1;
      cnt_q        <= '0;
      scan_q       <= '0;
      first_fall_q <= 1'b0;
      start_q      <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      board_q      <= board_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      cnt_q        <= cnt_d;
      scan_q       <= scan_d;
      first_fall_q <= first_fall_d;
      start_q      <= start_btn;
      left_q       <= btn_left;
      right_q      <= btn_right;
    end
  end

  // Display read: settled row, plus the falling bar when it sits on that row.
  always_comb begin
    disp_bits = board_q[disp_row];
    if (state_q == S_FALL && disp_row == y_q) disp_bits = disp_bits | mask_cur;
  end

  assign change_shape = first_fall_q;
  assign stop         = (state_q == S_MERGE);
  assign clear        = (state_q == S_SHIFT);
  assign start_over   = (state_q != S_IDLE);
  assign game_over    = (state_q == S_OVER);
  assign piece_x      = x_q;
  assign piece_y      = y_q;

endmodule

// File: tb/tb_tetris_board.sv
// tb_tetris_board: directed bench for tetris_board on a 4x4 field with a
// two-cycle gravity tick. Inputs change and outputs are read 1 ns after the
// rising edge.
module tb_tetris_board;

  localparam int ROWS = 4, COLS = 4, TICK_DIV = 2;

  logic        clock = 1'b0;
  logic        ctrl_reset, start_btn, btn_left, btn_right, btn_drop;
  logic [31:0] shape_in;
  logic [1:0]  disp_row;
  logic [3:0]  disp_bits;
  logic        change_shape, stop, clear, start_over, game_over;
  logic [1:0]  piece_x, piece_y;

  int n_vec = 0;
  int n_err = 0;

  tetris_board #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .start_btn(start_btn),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
    .shape_in(shape_in), .disp_row(disp_row), .disp_bits(disp_bits),
    .change_shape(change_shape), .stop(stop), .clear(clear),
    .start_over(start_over), .game_over(game_over),
    .piece_x(piece_x), .piece_y(piece_y)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_rows(input string tag, input logic [3:0] exp);
    for (int r = 0; r < ROWS; r++) begin
      disp_row = 2'(r);
      #1;
      check(tag, disp_bits, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    ctrl_reset = 1'b0;
    start_btn = 0; btn_left = 0; btn_right = 0; btn_drop = 0;
    #1;
    check("rst_stop", stop, 0);
    check("rst_clear", clear, 0);
    check("rst_change_shape", change_shape, 0);
    check("rst_start_over", start_over, 0);
    check("rst_game_over", game_over, 0);
    check("rst_piece_x", piece_x, 0);
    check("rst_piece_y", piece_y, 0);
    check_rows("rst_rows", 4'b0000);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b1;
  endtask

  // Leaves the bench at the first FALL cycle (gravity counter 0).
  task automatic start_game(input logic [31:0] shape);
    shape_in  = shape;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  // One-cycle press then one-cycle release: 0=left 1=right 2=both.
  task automatic press(input int which);
    btn_left  = (which == 0 || which == 2);
    btn_right = (which == 1 || which == 2);
    step();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    step();
  endtask

  initial begin
    int clr_cnt, clr_at, cs_at, cs_cnt, stop_cnt, cyc;
    ctrl_reset = 1'b1; start_btn = 0; btn_left = 0; btn_right = 0; btn_drop = 0;
    shape_in = '0; disp_row = '0;

    // Reset then start with w=2.
    do_reset();
    shape_in  = 32'd1;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("spawn_change_shape", change_shape, 0);
    check("spawn_start_over", start_over, 1);
    check("spawn_game_over", game_over, 0);
    step();
    check("fall0_change_shape", change_shape, 1);
    check("fall0_piece_x", piece_x, 1);
    check("fall0_piece_y", piece_y, 0);
    disp_row = 2'd0;
    #1;
    check("fall0_overlay", disp_bits, 4'b0110);
    step();
    check("fall1_change_shape", change_shape, 0);

    // Full-width bar: fall to the bottom, clear the row.
    do_reset();
    start_game(32'd3);
    check("lc_x", piece_x, 0);
    check("lc_y0", piece_y, 0);
    step(); step();
    check("lc_y1", piece_y, 1);
    step(); step();
    check("lc_y2", piece_y, 2);
    step(); step();
    check("lc_y3", piece_y, 3);
    step(); step();
    check("lc_stop", stop, 1);
    clr_cnt = 0; clr_at = 0; cs_at = 0; stop_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (clear) begin clr_cnt++; clr_at = i; end
      if (stop) stop_cnt++;
      if (change_shape && cs_at == 0) cs_at = i;
      if (i == 7) check_rows("lc_rows_empty", 4'b0000);
    end
    check("lc_clear_count", clr_cnt, 1);
    check("lc_clear_cycle", clr_at, 2);
    check("lc_stop_once", stop_cnt, 0);
    check("lc_next_fall_cycle", cs_at, 8);

    // Left wall.
    do_reset();
    start_game(32'd0);
    check("wl_x_start", piece_x, 1);
    press(0);
    check("wl_x_after1", piece_x, 0);
    press(0);
    press(0);
    check("wl_x_after3", piece_x, 0);
    check("wl_y", piece_y, 3);

    // Right wall, with a held button counting once.
    do_reset();
    start_game(32'd0);
    btn_right = 1'b1;
    step(); step(); step();
    btn_right = 1'b0;
    check("wr_held_once", piece_x, 2);
    step();
    press(1);
    check("wr_x3", piece_x, 3);
    press(1);
    check("wr_x_wall", piece_x, 3);
    check("wr_landed", stop, 1);

    // Both edges together, and an edge on a tick cycle.
    do_reset();
    start_game(32'd0);
    press(2);
    check("both_no_move", piece_x, 1);
    step();
    btn_left = 1'b1;
    step();
    btn_left = 1'b0;
    check("tick_edge_dropped", piece_x, 1);

    // Stack four single cells in column 1; fifth spawn ends the game.
    do_reset();
    shape_in  = 32'd0;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    cs_cnt = 0; stop_cnt = 0; cyc = 0;
    while (!game_over && cyc < 400) begin
      if (change_shape) cs_cnt++;
      if (stop) stop_cnt++;
      step();
      cyc++;
    end
    check("go_reached", game_over, 1);
    check("go_change_shapes", cs_cnt, 4);
    check("go_stops", stop_cnt, 4);
    check_rows("go_column", 4'b0010);
    for (int i = 0; i < 3; i++) begin
      step();
      check("go_no_change_shape", change_shape, 0);
      check("go_no_stop", stop, 0);
      check("go_held", game_over, 1);
    end
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("restart_game_over", game_over, 0);
    check("restart_start_over", start_over, 0);
    check_rows("restart_rows", 4'b0000);

    // Hard-drop button.
    do_reset();
    start_game(32'd0);
    btn_drop = 1'b1;
    step();
    btn_drop = 1'b0;
`ifdef TETRIS_HARD_DROP_EN
    check("hd_y1", piece_y, 1);
    step();
    check("hd_y2", piece_y, 2);
    step();
    check("hd_y3", piece_y, 3);
    step();
    check("hd_stop", stop, 1);
`else
    check("hd_y1", piece_y, 0);
    step();
    check("hd_y2", piece_y, 1);
    step();
    check("hd_y3", piece_y, 1);
    step();
    check("hd_stop", stop, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
